// File: rtl/iiitb_brg_tx_sched.sv
// Round-robin scheduler that shares one baud generator and one 8N1 transmitter among NREQ clients.
// Define IIITB_BRG_TX_SCHED_PARITY_EN to append an even-parity bit (11-bit frames).
module iiitb_brg_tx_sched #(
  parameter int NREQ    = 2,
  parameter int CFG_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_sel,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              done,
  output logic              busy,
  output logic [1:0]        brg_sel,
  output logic              brg_reset,
  input  logic              brg_clkout,
  output logic              txd
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam int CW = $clog2(CFG_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARB,
    S_CFG,
    S_SYNC,
    S_START,
    S_DATA,
`ifdef IIITB_BRG_TX_SCHED_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic [CW-1:0]   cfg_q, cfg_d;
  logic            txd_q, txd_d;
  logic            clkout_q;
  logic            tick;
`ifdef IIITB_BRG_TX_SCHED_PARITY_EN
  logic            par_q, par_d;
`endif

  logic            arb_vld;
  logic [IW-1:0]   arb_idx;
  logic [1:0]      pick_sel;
  logic [7:0]      pick_dat;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NREQ);
  endfunction

  assign tick = brg_clkout & ~clkout_q;

  // Descending scan so the candidate closest to the pointer is the last (winning) write.
  always_comb begin
    arb_vld  = 1'b0;
    arb_idx  = '0;
    pick_sel = '0;
    pick_dat = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap(int'(rr_q) + k)]) begin
        arb_vld = 1'b1;
        arb_idx = wrap(int'(rr_q) + k);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IW'(i)) begin
        pick_sel = req_sel[2*i +: 2];
        pick_dat = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    cfg_d   = cfg_q;
    txd_d   = txd_q;
`ifdef IIITB_BRG_TX_SCHED_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_vld) begin
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
          gidx_d  = arb_idx;
          shift_d = pick_dat;
          sel_d   = pick_sel;
          cfg_d   = '0;
`ifdef IIITB_BRG_TX_SCHED_PARITY_EN
          par_d   = ^pick_dat;
`endif
          state_d = S_CFG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CFG: begin
        if (cfg_q == CW'(CFG_CYC - 1)) state_d = S_SYNC;
        else cfg_d = cfg_q + 1'b1;
      end
      S_SYNC: begin
        if (tick) begin
          txd_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          txd_d   = shift_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
`ifdef IIITB_BRG_TX_SCHED_PARITY_EN
            txd_d   = par_q;
            state_d = S_PARITY;
`else
            txd_d   = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            bit_d   = bit_q + 1'b1;
          end
        end
      end
`ifdef IIITB_BRG_TX_SCHED_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          txd_d   = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) state_d = S_DONE;
      end
      S_DONE: begin
        gnt_d   = '0;
        rr_d    = wrap(int'(gidx_q) + 1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_q     <= '0;
      gidx_q   <= '0;
      gnt_q    <= '0;
      sel_q    <= 2'b00;
      shift_q  <= '0;
      bit_q    <= '0;
      cfg_q    <= '0;
      txd_q    <= 1'b1;
      clkout_q <= 1'b0;
`ifdef IIITB_BRG_TX_SCHED_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gidx_q   <= gidx_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      cfg_q    <= cfg_d;
      txd_q    <= txd_d;
      clkout_q <= brg_clkout;
`ifdef IIITB_BRG_TX_SCHED_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Generator is held in reset until the rate select has settled.
  assign brg_reset = (state_q == S_IDLE) || (state_q == S_ARB) || (state_q == S_CFG);
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign gnt       = gnt_q;
  assign brg_sel   = sel_q;
  assign txd       = txd_q;

endmodule
